// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & {30'h3FFF_FFFF, ~WORD_ALIGN_MASK};
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts memory cycles without acknowledge; expired flags the last allowed wait cycle.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The cycle that would make the count reach TIMEOUT_CYCLES is the abort cycle.
  assign o_expired = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: fetch and data channels onto one memory port with timeout.
// IDLE: arbitrate | I_BUSY: fetch on bus | D_BUSY: data on bus | RESP: one-cycle ack
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  state_t      r_state;
  grant_t      r_last_grant;
  logic        r_i_ack, r_i_err, r_d_ack, r_d_err;
  logic [31:0] r_i_rdata, r_d_rdata;
  logic        r_m_req, r_m_we;
  logic [31:0] r_m_addr, r_m_wdata;

  logic        w_busy;
  logic        w_expired;
  logic        w_any_req;
  grant_t      w_grant;

  assign w_busy    = (r_state == I_BUSY) || (r_state == D_BUSY);
  assign w_any_req = i_req || d_req;

  always_comb begin
    w_grant = INSTR;
    if (i_req && d_req) begin
      w_grant = (r_last_grant == INSTR) ? DATA : INSTR;
    end else if (d_req) begin
      w_grant = DATA;
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_busy),
    .i_enable (w_busy && !m_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= INSTR;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
    end else begin
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_grant;
            if (w_grant == DATA) begin
              if (is_misaligned(d_addr)) begin
                r_state   <= RESP;
                r_d_ack   <= 1'b1;
                r_d_err   <= 1'b1;
                r_d_rdata <= ERR_DATA;
              end else begin
                r_state   <= D_BUSY;
                r_m_req   <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= word_addr(d_addr);
                r_m_wdata <= d_wdata;
              end
            end else begin
              r_state   <= I_BUSY;
              r_m_req   <= 1'b1;
              r_m_we    <= 1'b0;
              r_m_addr  <= word_addr(i_addr);
              r_m_wdata <= '0;
            end
          end
        end
        I_BUSY: begin
          if (m_ack) begin
            r_state   <= RESP;
            r_m_req   <= 1'b0;
            r_i_ack   <= 1'b1;
            r_i_rdata <= m_rdata;
          end else if (w_expired) begin
            r_state   <= RESP;
            r_m_req   <= 1'b0;
            r_i_ack   <= 1'b1;
            r_i_err   <= 1'b1;
            r_i_rdata <= ERR_DATA;
          end
        end
        D_BUSY: begin
          if (m_ack) begin
            r_state   <= RESP;
            r_m_req   <= 1'b0;
            r_d_ack   <= 1'b1;
            r_d_rdata <= r_m_we ? 32'h0000_0000 : m_rdata;
          end else if (w_expired) begin
            r_state   <= RESP;
            r_m_req   <= 1'b0;
            r_d_ack   <= 1'b1;
            r_d_err   <= 1'b1;
            r_d_rdata <= ERR_DATA;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i_ack   = r_i_ack;
  assign i_err   = r_i_err;
  assign i_rdata = r_i_rdata;
  assign d_ack   = r_d_ack;
  assign d_err   = r_d_err;
  assign d_rdata = r_d_rdata;
  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: scoreboard of expected acks plus inline timing checks.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack, i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  typedef struct packed {
    logic        chan;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_got, mon_exp;
  int          checks = 0;
  int          errors = 0;
  int          wait_cfg = 0;
  int          wc = 0;
  logic [31:0] rdata_cfg = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (ERRD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ack  (i_ack),
    .i_err  (i_err),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack  (d_ack),
    .d_err  (d_err),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack  (m_ack)
  );

  // Memory model: acknowledges after wait_cfg cycles of m_req.
  always @(negedge clk) begin
    if (m_req) begin
      m_ack   = (wc == wait_cfg);
      m_rdata = m_ack ? rdata_cfg : 32'h0BAD_0BAD;
      wc      = wc + 1;
    end else begin
      m_ack   = 1'b0;
      m_rdata = 32'h0BAD_0BAD;
      wc      = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (i_ack && d_ack) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL dual_ack: i_ack=%b d_ack=%b, required at most one", i_ack, d_ack);
      end
      if (i_ack || d_ack) begin
        checks  = checks + 1;
        mon_got = '{chan: d_ack, err: (d_ack ? d_err : i_err), rdata: (d_ack ? d_rdata : i_rdata)};
        if (sb_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_ack: got chan=%b err=%b rdata=%h, none expected",
                   mon_got.chan, mon_got.err, mon_got.rdata);
        end else begin
          mon_exp = sb_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors = errors + 1;
            $display("FAIL ack_content: got chan=%b err=%b rdata=%h, required chan=%b err=%b rdata=%h",
                     mon_got.chan, mon_got.err, mon_got.rdata,
                     mon_exp.chan, mon_exp.err, mon_exp.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    checks = checks + 1;
    if ({i_ack, i_err, d_ack, d_err, m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: m_req=%b m_addr=%h i_ack=%b d_ack=%b, required all 0",
               m_req, m_addr, i_ack, d_ack);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (m_req !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL idle_no_req: m_req=%b, required 0", m_req);
    end
  endtask

  task automatic test_fetch_waits();
    rdata_cfg = 32'h2402_0005;
    wait_cfg  = 3;
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h8002_0000;
    sb_q.push_back('{chan: 1'b0, err: 1'b0, rdata: 32'h2402_0005});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (m_req !== 1'b1 || m_addr !== 32'h8002_0000 || m_we !== 1'b0 || i_ack !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL fetch_bus_c%0d: m_req=%b m_addr=%h m_we=%b i_ack=%b, required 1 80020000 0 0",
                 k, m_req, m_addr, m_we, i_ack);
      end
    end
    @(negedge clk);
    checks = checks + 1;
    if (m_req !== 1'b0 || i_ack !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL fetch_ack_c5: m_req=%b i_ack=%b, required 0 1", m_req, i_ack);
    end
    i_req = 1'b0;
  endtask

  task automatic test_round_robin();
    logic        exp_chan[3];
    logic [31:0] exp_addr;
    int          n;
    exp_chan[0] = 1'b1;
    exp_chan[1] = 1'b0;
    exp_chan[2] = 1'b1;
    rdata_cfg = 32'h1357_9BDF;
    wait_cfg  = 0;
    @(negedge clk);
    i_addr = 32'h0000_0103;
    d_addr = 32'h0000_0200;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      sb_q.push_back('{chan: exp_chan[t], err: 1'b0, rdata: 32'h1357_9BDF});
    end
    for (int t = 0; t < 3; t++) begin
      exp_addr = exp_chan[t] ? 32'h0000_0200 : 32'h0000_0100;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (m_req !== 1'b1 && n < 10);
      checks = checks + 1;
      if (m_req !== 1'b1 || m_addr !== exp_addr) begin
        errors = errors + 1;
        $display("FAIL rr_grant_%0d: m_req=%b m_addr=%h, required 1 %h", t, m_req, m_addr, exp_addr);
      end
      @(negedge clk);
      checks = checks + 1;
      if ({i_ack, d_ack} !== (exp_chan[t] ? 2'b01 : 2'b10)) begin
        errors = errors + 1;
        $display("FAIL rr_ack_%0d: i_ack=%b d_ack=%b, required chan=%b two cycles after grant",
                 t, i_ack, d_ack, exp_chan[t]);
      end
      if (t == 2) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    int n;
    rdata_cfg = 32'hFFFF_1234;
    wait_cfg  = 1;
    @(negedge clk);
    d_we    = 1'b1;
    d_addr  = 32'h8011_FFFC;
    d_wdata = 32'hCAFE_F00D;
    d_req   = 1'b1;
    sb_q.push_back('{chan: 1'b1, err: 1'b0, rdata: 32'h0000_0000});
    @(negedge clk);
    checks = checks + 1;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hCAFE_F00D || m_addr !== 32'h8011_FFFC) begin
      errors = errors + 1;
      $display("FAIL write_bus: m_req=%b m_we=%b m_wdata=%h m_addr=%h, required 1 1 cafef00d 8011fffc",
               m_req, m_we, m_wdata, m_addr);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_ack !== 1'b1 && n < 8);
    checks = checks + 1;
    if (d_ack !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL write_ack_timeout: d_ack=%b, required 1", d_ack);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic test_misaligned();
    int n;
    rdata_cfg = 32'h7777_7777;
    wait_cfg  = 0;
    @(negedge clk);
    d_addr = 32'h8012_0002;
    d_req  = 1'b1;
    sb_q.push_back('{chan: 1'b1, err: 1'b1, rdata: ERRD});
    @(negedge clk);
    checks = checks + 1;
    if (d_ack !== 1'b1 || m_req !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL misaligned_ack: d_ack=%b m_req=%b, required 1 0", d_ack, m_req);
    end
    d_req = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (m_req !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL misaligned_no_mem: m_req=%b, required 0", m_req);
    end
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    i_req  = 1'b1;
    d_req  = 1'b1;
    sb_q.push_back('{chan: 1'b0, err: 1'b0, rdata: 32'h7777_7777});
    sb_q.push_back('{chan: 1'b1, err: 1'b0, rdata: 32'h7777_7777});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_req !== 1'b1 && n < 10);
    checks = checks + 1;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_0100) begin
      errors = errors + 1;
      $display("FAIL misaligned_updates_rr: m_req=%b m_addr=%h, required 1 00000100", m_req, m_addr);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (i_ack !== 1'b1 && n < 10);
    i_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_ack !== 1'b1 && n < 10);
    checks = checks + 1;
    if (d_ack !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL misaligned_followup_ack: d_ack=%b, required 1", d_ack);
    end
    d_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    wait_cfg = 1000;
    @(negedge clk);
    i_addr = 32'h0000_4000;
    i_req  = 1'b1;
    sb_q.push_back('{chan: 1'b0, err: 1'b1, rdata: ERRD});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (m_req !== 1'b1 || i_ack !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL timeout_hold_c%0d: m_req=%b i_ack=%b, required 1 0", k, m_req, i_ack);
      end
    end
    @(negedge clk);
    checks = checks + 1;
    if (m_req !== 1'b0 || i_ack !== 1'b1 || i_err !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL timeout_abort: m_req=%b i_ack=%b i_err=%b, required 0 1 1", m_req, i_ack, i_err);
    end
    i_req = 1'b0;
    wait_cfg  = 2;
    rdata_cfg = 32'h0F0F_0F0F;
    @(negedge clk);
    i_req = 1'b1;
    sb_q.push_back('{chan: 1'b0, err: 1'b0, rdata: 32'h0F0F_0F0F});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (i_ack !== 1'b1 && n < 10);
    checks = checks + 1;
    if (i_ack !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL timeout_recover: i_ack=%b, required 1", i_ack);
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int n;
    wait_cfg = 1000;
    @(negedge clk);
    d_addr = 32'h0000_0300;
    d_we   = 1'b0;
    d_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (m_req !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL dbusy_before_reset: m_req=%b, required 1", m_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks = checks + 1;
    if ({i_ack, i_err, d_ack, d_err, m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      errors = errors + 1;
      $display("FAIL async_reset: m_req=%b m_addr=%h d_ack=%b, required all 0", m_req, m_addr, d_ack);
    end
    @(negedge clk);
    @(negedge clk);
    wait_cfg  = 0;
    rdata_cfg = 32'h4444_5555;
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    i_req  = 1'b1;
    d_req  = 1'b1;
    reset  = 1'b1;
    sb_q.push_back('{chan: 1'b1, err: 1'b0, rdata: 32'h4444_5555});
    sb_q.push_back('{chan: 1'b0, err: 1'b0, rdata: 32'h4444_5555});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_req !== 1'b1 && n < 10);
    checks = checks + 1;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_0200) begin
      errors = errors + 1;
      $display("FAIL post_reset_tie: m_req=%b m_addr=%h, required 1 00000200", m_req, m_addr);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_ack !== 1'b1 && n < 10);
    d_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (i_ack !== 1'b1 && n < 10);
    checks = checks + 1;
    if (i_ack !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL post_reset_second: i_ack=%b, required 1", i_ack);
    end
    i_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_waits();
    test_round_robin();
    test_write();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_leftover: %0d pending, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the core's instruction-fetch channel and data channel, and one shared memory/bus port with variable wait states.
- Sits directly downstream of the multicycle core: it consumes the instruction and data addresses and requests, and produces the returned words.
- Arbitration is round-robin when both channels are pending.
- Misaligned data accesses are rejected without touching memory.
- A memory access that is not acknowledged within a bounded number of cycles is aborted with an error.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles m_req is held without m_ack before the access is aborted; legal range 1..255.
- ERR_DATA, 32'h0000_0000: value returned on i_rdata/d_rdata for an errored access.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  reset, asynchronous, active-low (0 = reset asserted).
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  32  fetch address; bits [1:0] ignored and forced to 0 on m_addr.
- i_rdata  out  32  fetched word; valid only while i_ack=1.
- i_ack  out  1  one-cycle completion pulse for the fetch channel.
- i_err  out  1  qualifies i_ack; 1 = timeout.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address; must be word aligned.
- d_wdata  in  32  write data.
- d_rdata  out  32  read word; valid only while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for the data channel.
- d_err  out  1  qualifies d_ack; 1 = misaligned or timeout.
- m_req  out  1  memory request, held until m_ack or timeout.
- m_we  out  1  memory write strobe.
- m_addr  out  32  memory word address (bits [1:0] = 0).
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; valid while m_ack=1.
- m_ack  in  1  memory completion; sampled only while m_req=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; last_grant=INSTR, so data wins the first tie; timeout counter 0.
  - All outputs 0: i_ack, i_err, d_ack, d_err, m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata.
  - Reset mid-access drops m_req immediately; that access is never acknowledged.
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE, grant rules:
  - Only i_req: grant INSTR.
  - Only d_req: grant DATA.
  - Both pending: grant the channel not granted last (round-robin).
  - Neither: stay in IDLE.
- Data grant with d_addr[1:0] != 0:
  - No memory access.
  - Next state RESP with d_ack=1, d_err=1, d_rdata=ERR_DATA.
  - last_grant is still updated to DATA.
- Otherwise, on grant: register m_addr, m_we (0 for fetch), m_wdata; m_req=1 from the next cycle. Next state I_BUSY or D_BUSY.
- I_BUSY / D_BUSY:
  - m_req, m_addr, m_we, m_wdata are held stable.
  - The counter increments each cycle in which m_ack=0.
  - On m_ack=1: capture m_rdata (reads), drop m_req, go to RESP with err=0.
  - If the counter reaches TIMEOUT_CYCLES without m_ack: drop m_req, go to RESP with err=1 and rdata=ERR_DATA.
  - m_ack and timeout in the same cycle: m_ack wins.
- RESP: exactly one cycle; the granted channel's ack=1 and its err as latched; then IDLE; counter cleared.
- Latency:
  - Request seen in IDLE at cycle N gives m_req=1 at N+1.
  - m_ack at cycle M gives ack at M+1.
  - Zero-wait memory (m_ack in the first m_req cycle): ack at N+2.
  - Misaligned access: ack at N+1.
- Requesters deassert req in the cycle after ack. A req still high when IDLE is re-entered is treated as a new request, so back-to-back transactions are legal.
- Write data is ignored by the requester; d_rdata=0 on successful writes.
- The ungranted channel's inputs are ignored until it is granted; no queueing beyond the req hold.
- m_ack while m_req=0 is ignored.

Decomposition:
- Package mem_arbiter_pkg:
  - enum state_t {IDLE, I_BUSY, D_BUSY, RESP};
  - enum grant_t {INSTR, DATA};
  - constant WORD_ALIGN_MASK = 2'b11.
- Sub-module mem_timeout_ctr: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1). All other logic lives in the top.

Test Plan:
1. Fetch only, memory acks after 3 wait cycles:
   - i_req=1, i_addr=32'h8002_0000 at cycle 0, m_rdata=32'h2402_0005.
   - Expect m_req cycles 1-4, m_addr=32'h8002_0000, m_we=0.
   - Expect i_ack=1, i_rdata=32'h2402_0005, i_err=0 at cycle 5.
2. Simultaneous i_req and d_req out of reset, both held, zero-wait memory:
   - Grant order DATA, INSTR, DATA.
   - Each ack 2 cycles after its grant; no cycle with both acks.
3. Data write d_we=1, d_addr=32'h8011_FFFC, d_wdata=32'hCAFE_F00D:
   - Expect m_we=1, m_wdata=32'hCAFE_F00D.
   - Expect d_ack with d_err=0 and d_rdata=0.
4. Misaligned read d_addr=32'h8012_0002:
   - m_req never asserts.
   - Expect d_ack=1, d_err=1, d_rdata=ERR_DATA on the next cycle.
5. TIMEOUT_CYCLES=4, memory never acks:
   - m_req high for exactly 4 cycles, then 0.
   - Expect i_ack=1, i_err=1; then a following request is served normally.
6. Assert reset=0 during D_BUSY:
   - m_req and all outputs go 0 asynchronously; no d_ack.
   - After release, the first tie grants DATA.
